// File: rtl/mult_if_pipe_pkg.sv
// ----------------------------------------------------------------------------
// mult_if_pipe_pkg: shared sizing helpers for the override priority pipeline
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mult_if_pipe_pkg;

  localparam int CNT_W = 16;

  function automatic int sel_width(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  // The override result is reported one past the last data channel.
  function automatic int ovr_index(input int n_ch);
    return n_ch;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_if_prio_enc.sv
// ----------------------------------------------------------------------------
// mult_if_prio_enc: lowest-active-condition priority encoder with polarity
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_if_prio_enc
  import mult_if_pipe_pkg::*;
#(
  parameter int              N_CH  = 5,
  parameter logic [N_CH-2:0] POL   = 4'b0101,
  parameter int              SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-2:0]  cond_i,
  output logic [SEL_W-1:0] win_o
);

  logic [N_CH-2:0] act;

  assign act = ~(cond_i ^ POL);

  // Scan from high to low so the lowest active channel is written last.
  always_comb begin
    win_o = SEL_W'(N_CH - 1);
    for (int i = N_CH - 2; i >= 0; i--) begin
      if (act[i]) win_o = SEL_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_if_pipe.sv
// ----------------------------------------------------------------------------
// mult_if_pipe: two-stage priority mux with late-inhibited data override
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_if_pipe
  import mult_if_pipe_pkg::*;
#(
  parameter int              N_CH    = 5,
  parameter int              W       = 1,
  parameter logic [N_CH-2:0] POL     = 4'b0101,
  parameter int              OVR_POS = 3,
  localparam int             SEL_W   = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] data_in,
  input  logic [N_CH-2:0]   cond,
  input  logic              ovr_cond,
  input  logic [W-1:0]      ovr_data,
  input  logic              late_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      data_out,
  output logic [SEL_W-1:0]  out_sel,
  output logic [CNT_W-1:0]  ovr_count
);

  localparam logic [SEL_W-1:0] OVR_SEL = SEL_W'(ovr_index(N_CH));

  logic [SEL_W-1:0] win;
  logic [W-1:0]     win_data;
  logic             pre;

  logic             s1_valid_q, s1_valid_d;
  logic [SEL_W-1:0] s1_win_q;
  logic [W-1:0]     s1_data_q;
  logic             s1_ovr_q;
  logic [W-1:0]     s1_odata_q;
  logic             s1_pre_q;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     data_out_q, data_out_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [CNT_W-1:0] ovr_count_q, ovr_count_d;

  logic s2_load;
  logic s1_adv;
  logic accept;
  logic take_ovr;

  mult_if_prio_enc #(
    .N_CH  (N_CH),
    .POL   (POL),
    .SEL_W (SEL_W)
  ) u_prio_enc (
    .cond_i (cond),
    .win_o  (win)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (win == SEL_W'(i)) win_data = data_in[i*W +: W];
    end
  end

  assign pre = (win < SEL_W'(OVR_POS));

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  // late_ctrl only steers this final 2:1 choice, sampled as stage 1 drains.
  assign take_ovr = s1_ovr_q && !late_ctrl && !s1_pre_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    out_sel_d   = out_sel_q;
    ovr_count_d = ovr_count_q;

    if (accept)      s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;

    if (s2_load) out_valid_d = s1_valid_q;

    if (s1_adv) begin
      data_out_d = take_ovr ? s1_odata_q : s1_data_q;
      out_sel_d  = take_ovr ? OVR_SEL    : s1_win_q;
    end

    if (out_valid_q && out_ready && (out_sel_q == OVR_SEL) && (ovr_count_q != '1))
      ovr_count_d = ovr_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_win_q    <= '0;
      s1_data_q   <= '0;
      s1_ovr_q    <= 1'b0;
      s1_odata_q  <= '0;
      s1_pre_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_sel_q   <= '0;
      ovr_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_win_q   <= win;
        s1_data_q  <= win_data;
        s1_ovr_q   <= ovr_cond;
        s1_odata_q <= ovr_data;
        s1_pre_q   <= pre;
      end
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      out_sel_q   <= out_sel_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign out_sel   = out_sel_q;
  assign ovr_count = ovr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_if_pipe.sv
// ----------------------------------------------------------------------------
// tb_mult_if_pipe: directed self-checking bench for mult_if_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mult_if_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] data_in;
  logic [3:0]  cond;
  logic        ovr_cond;
  logic [7:0]  ovr_data;
  logic        late_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_out;
  logic [2:0]  out_sel;
  logic [15:0] ovr_count;

  int checks   = 0;
  int failures = 0;

  mult_if_pipe #(
    .N_CH    (5),
    .W       (8),
    .POL     (4'b0101),
    .OVR_POS (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .cond      (cond),
    .ovr_cond  (ovr_cond),
    .ovr_data  (ovr_data),
    .late_ctrl (late_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_sel   (out_sel),
    .ovr_count (ovr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Single request through an idle pipe; called at posedge+1 with out_ready high.
  task automatic send(input string tag, input logic [3:0] c, input logic ov,
                      input logic [7:0] od, input logic lc, input logic lx,
                      input logic [39:0] d, input logic [2:0] esel, input logic [7:0] edat);
    cond = c; ovr_cond = ov; ovr_data = od; data_in = d; late_ctrl = lc; in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; late_ctrl = lx;
    cond = ~c; ovr_cond = ~ov; ovr_data = ~od; data_in = ~d;
    @(negedge clk);
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    late_ctrl = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_sel"}, 64'(out_sel), 64'(esel));
    check({tag, "_data"}, 64'(data_out), 64'(edat));
    @(posedge clk); #1;
  endtask

  // Back-to-back stream table: winners and data hand-derived for POL=0101, OVR_POS=3.
  logic [3:0] s_cond [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0110,
                             4'b1010, 4'b1011, 4'b1110, 4'b0011};
  logic       s_ovr  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [2:0] e_sel  [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd0, 3'd2, 3'd0};
  logic [7:0] e_dat  [8] = '{8'h00, 8'h11, 8'h23, 8'h32, 8'hA4, 8'h50, 8'h62, 8'h70};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; cond = '0; ovr_cond = 1'b0;
    ovr_data = '0; late_ctrl = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_out_sel", 64'(out_sel), 64'(0));
    check("rst_ovr_count", 64'(ovr_count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    send("ovr_taken", 4'b0010, 1'b1, 8'h01, 1'b0, 1'b0, 40'h44_33_22_11_00, 3'd5, 8'h01);
    check("ovr_count_1", 64'(ovr_count), 64'(1));
    send("late_inhibit", 4'b0010, 1'b1, 8'h01, 1'b0, 1'b1, 40'h44_33_22_11_00, 3'd3, 8'h33);
    check("ovr_count_late", 64'(ovr_count), 64'(1));
    send("pre_block", 4'b0001, 1'b1, 8'h01, 1'b0, 1'b0, 40'h55_44_33_22_11, 3'd0, 8'h11);
    send("fallthru", 4'b1010, 1'b1, 8'hEE, 1'b0, 1'b1, 40'h55_44_33_22_11, 3'd4, 8'h55);
    check("ovr_count_pre", 64'(ovr_count), 64'(1));

    // Eight back-to-back requests with a downstream stall in cycles 3..5.
    fork
      begin : drv
        logic [39:0] d;
        logic acc;
        for (int k = 0; k < 8; k++) begin
          for (int i = 0; i < 5; i++) d[i*8 +: 8] = 8'(16 * k + i);
          data_in = d; cond = s_cond[k]; ovr_cond = s_ovr[k];
          ovr_data = 8'(8'hA0 + k); in_valid = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b0;
      end
      begin : rdy
        for (int c = 0; c < 40; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      begin : mon
        int idx;
        logic held;
        logic [7:0] h_dat;
        logic [2:0] h_sel;
        idx = 0; held = 1'b0; h_dat = '0; h_sel = '0;
        for (int t = 0; t < 60 && idx < 8; t++) begin
          @(negedge clk);
          if (out_valid && !out_ready) begin
            check("stall_in_ready", 64'(in_ready), 64'(0));
            if (held) begin
              check("hold_data", 64'(data_out), 64'(h_dat));
              check("hold_sel", 64'(out_sel), 64'(h_sel));
            end
            held = 1'b1; h_dat = data_out; h_sel = out_sel;
          end else begin
            held = 1'b0;
            if (out_valid && out_ready) begin
              check($sformatf("stream%0d_sel", idx), 64'(out_sel), 64'(e_sel[idx]));
              check($sformatf("stream%0d_data", idx), 64'(data_out), 64'(e_dat[idx]));
              idx++;
            end
          end
        end
        check("stream_count", 64'(idx), 64'(8));
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("stream_idle_valid", 64'(out_valid), 64'(0));
    check("ovr_count_2", 64'(ovr_count), 64'(2));

    // Fill both stages, then reset asynchronously between clock edges.
    out_ready = 1'b0;
    cond = 4'b0010; ovr_cond = 1'b1; ovr_data = 8'h77; data_in = 40'h44_33_22_11_00; in_valid = 1'b1;
    @(posedge clk); #1;
    cond = 4'b0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 64'(out_valid), 64'(1));
    check("full_in_ready", 64'(in_ready), 64'(0));
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_ovr_count", 64'(ovr_count), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(out_valid), 64'(0));
    send("post_rst", 4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 40'h55_44_33_22_11, 3'd0, 8'h11);
    check("post_rst_count", 64'(ovr_count), 64'(0));

    // Saturation: 65534 streamed overrides, then three more.
    cond = 4'b0010; ovr_cond = 1'b1; ovr_data = 8'h5A; late_ctrl = 1'b0;
    data_in = 40'h44_33_22_11_00; in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat_fffe", 64'(ovr_count), 64'(16'hFFFE));
    for (int n = 0; n < 3; n++)
      send("sat_send", 4'b0010, 1'b1, 8'h5A, 1'b0, 1'b0, 40'h44_33_22_11_00, 3'd5, 8'h5A);
    check("sat_ffff", 64'(ovr_count), 64'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_if_pipe.md
MULT_IF_PIPE -- requirements
Module: mult_if_pipe

Interface
REQ-001 Parameter N_CH, default 5, is the number of priority data channels (2..16); channel N_CH-1 is the default (fall-through) channel.
REQ-002 Parameter W, default 1, is the data width per channel (1..64).
REQ-003 Parameter POL, N_CH-1 bits, default 4'b0101, is the condition polarity; bit i=1 means cond[i] is active-high, 0 means active-low.
REQ-004 Parameter OVR_POS, default 3, is the priority position (0..N_CH-1) below which the override channel cannot pre-empt the normal winner.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  request presented.
REQ-008 in_ready  output  1  stage 1 can accept.
REQ-009 data_in  input  N_CH*W  channel i in bits [i*W +: W].
REQ-010 cond  input  N_CH-1  per-channel select conditions, qualified by POL.
REQ-011 ovr_cond  input  1  override request, captured with the request.
REQ-012 ovr_data  input  W  override data, captured with the request.
REQ-013 late_ctrl  input  1  late-arriving override inhibit, sampled at the stage 1 to stage 2 transfer, never at capture.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts.
REQ-016 data_out  output  W  selected data, registered.
REQ-017 out_sel  output  clog2(N_CH+1)  chosen channel index; value N_CH means override.
REQ-018 ovr_count  output  16  saturating count of delivered override results.

Function
REQ-019 Cond i is active when cond[i]==POL[i]; the winner is the lowest active i in 0..N_CH-2, else N_CH-1.
REQ-020 On in_valid&&in_ready, stage 1 registers the winner index, the winner data, ovr_cond, ovr_data and pre = (winner < OVR_POS).
REQ-021 On the stage 1 to stage 2 transfer: if ovr_cond && !late_ctrl && !pre, data_out<=ovr_data and out_sel<=N_CH; otherwise data_out<=winner data and out_sel<=winner.
REQ-022 The late_ctrl value sampled is the one present in the transfer cycle; late_ctrl feeds only the final 2:1 select, never the priority encoder.
REQ-023 Latency is 2 cycles from accept to out_valid when out_ready is held high; throughput is one result per cycle.
REQ-024 Stage 2 loads when !out_valid || out_ready; stage 1 advances when it is valid and stage 2 loads.
REQ-025 in_ready = !s1_valid || stage 2 loads (bubble collapse); in_ready has no combinational path from in_valid.
REQ-026 While out_valid && !out_ready, data_out, out_sel and out_valid are held stable.
REQ-027 ovr_count increments by 1 on each out_valid&&out_ready handshake with out_sel==N_CH, saturates at 16'hFFFF and never wraps.
REQ-028 Simultaneous accept and output handshake in one cycle loses no data and duplicates no data.

Reset
REQ-029 While rst_n is low: s1_valid=0, out_valid=0, data_out=0, out_sel=0, ovr_count=0, and in_ready=1 after the first edge.
REQ-030 Reset asserted mid-operation discards all in-flight requests; the first accept after deassertion behaves as if from idle.

Structure
REQ-031 A shared package holds the out_sel width function, the override-index constant (N_CH) and the counter width (16).
REQ-032 One sub-module, mult_if_prio_enc, implements REQ-019 combinationally (cond and POL in, winner index out); the pipeline and override logic stay in mult_if_pipe.

Verification
REQ-033 Defaults, cond=4'b0010, ovr_cond=1, late_ctrl=0, ovr_data=1 -> winner 3, pre=0, data_out=1, out_sel=5 two cycles after accept, ovr_count=1.
REQ-034 Same stimulus with late_ctrl=1 in the transfer cycle and late_ctrl=0 in the capture cycle -> out_sel=3, data_out=data_in[3], ovr_count unchanged.
REQ-035 cond=4'b0001, ovr_cond=1, late_ctrl=0 -> winner 0, pre=1, out_sel=0, data_out=data_in[0].
REQ-036 Back-to-back 8 accepts with out_ready low for cycles 3-5 -> in_ready low once both stages are full, all 8 results in order, no loss or duplicates, output held stable while stalled.
REQ-037 Preload ovr_count=16'hFFFE with override results, then 3 more override handshakes -> ovr_count stays at 16'hFFFF.
REQ-038 Assert rst_n=0 with both stages valid -> out_valid=0 and ovr_count=0 immediately (asynchronous); after release the next accept appears 2 cycles later.
